// File: rtl/mac_result_drain.sv
// mac_result_drain: captures a frame of MAC results (optional ReLU) and streams them out one channel per transfer
module mac_result_drain #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH = 16
) (
  input  logic                         clk,
  input  logic                         arst_in,
  input  logic                         capture_valid,
  output logic                         capture_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] res_vec,
  input  logic                         relu_en,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(NUM_CH)-1:0]    out_ch,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic [15:0]                  frame_count
);
  localparam int CW = $clog2(NUM_CH);
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] mem [NUM_CH];
  logic [CW-1:0] cnt;
  logic last;
  assign last = cnt == CW'(NUM_CH - 1);
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = capture_valid ? DRAIN : IDLE;
    else state_nx = (out_ready && last) ? IDLE : DRAIN;
  end
  always_comb begin
    capture_ready = state == IDLE;
    out_valid = state == DRAIN;
    out_last = out_valid && last;
    out_data = mem[cnt];
    out_ch = cnt;
  end
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      state <= IDLE;
      cnt <= '0;
      frame_count <= '0;
      for (int k = 0; k < NUM_CH; k++) mem[k] <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && capture_valid) begin
        cnt <= '0;
        for (int k = 0; k < NUM_CH; k++)
          mem[k] <= (relu_en && res_vec[k*DATA_WIDTH+DATA_WIDTH-1]) ? '0 : res_vec[k*DATA_WIDTH +: DATA_WIDTH];
      end else if (state == DRAIN && out_ready) begin
        cnt <= last ? '0 : cnt + 1'b1;
        if (last) frame_count <= frame_count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_mac_result_drain.sv
// tb_mac_result_drain: scoreboard bench for capture, ReLU, backpressure, blocked capture, reset and frame_count wrap
module tb_mac_result_drain;
  localparam int DW = 16;
  localparam int N = 16;
  logic clk = 0;
  logic arst_in = 1;
  logic capture_valid = 0;
  logic capture_ready;
  logic [N*DW-1:0] res_vec = '0;
  logic relu_en = 0;
  logic [DW-1:0] out_data;
  logic [$clog2(N)-1:0] out_ch;
  logic out_valid;
  logic out_ready = 0;
  logic out_last;
  logic [15:0] frame_count;
  typedef struct {logic [DW-1:0] d; int ch; bit last;} exp_t;
  exp_t q[$];
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  mac_result_drain #(.DATA_WIDTH(DW), .NUM_CH(N)) dut (
    .clk(clk), .arst_in(arst_in), .capture_valid(capture_valid), .capture_ready(capture_ready),
    .res_vec(res_vec), .relu_en(relu_en), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .frame_count(frame_count)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [N*DW-1:0] ramp();
    logic [N*DW-1:0] v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(k - 8);
    return v;
  endfunction
  task automatic capture(input logic [N*DW-1:0] v, input bit relu);
    int w = 0;
    logic [DW-1:0] d;
    while (!capture_ready && w < 50) begin tick(); w++; end
    chk("cap_ready", capture_ready, 1);
    res_vec = v;
    relu_en = relu;
    capture_valid = 1;
    for (int k = 0; k < N; k++) begin
      d = v[k*DW +: DW];
      q.push_back('{(relu && d[DW-1]) ? '0 : d, k, k == N - 1});
    end
    tick();
    capture_valid = 0;
    relu_en = ~relu;
    res_vec = ~v;
  endtask
  // mode 0: ready held high; mode 1: ready pattern 1,0,0,1,0,0...
  task automatic drain(input int mode, input int pulse_ch, input int rst_ch);
    int cyc = 0;
    bit held = 0;
    logic [DW-1:0] hd;
    int hc;
    bit hl;
    exp_t e;
    chk("first_valid", out_valid, 1);
    while (q.size() > 0 && cyc < 200) begin
      out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      chk("valid", out_valid, 1);
      if (held) begin
        chk("hold_data", out_data, hd);
        chk("hold_ch", out_ch, hc);
        chk("hold_last", out_last, hl);
      end
      if (int'(out_ch) == rst_ch) begin
        arst_in = 1;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_fc", frame_count, 0);
        chk("rst_ready", capture_ready, 1);
        chk("rst_data", out_data, 0);
        chk("rst_ch", out_ch, 0);
        chk("rst_last", out_last, 0);
        q.delete();
        tick();
        arst_in = 0;
        out_ready = 0;
        return;
      end
      if (int'(out_ch) == pulse_ch) begin
        capture_valid = 1;
        res_vec = ~ramp();
        chk("blk_ready", capture_ready, 0);
      end else capture_valid = 0;
      if (out_ready) begin
        e = q.pop_front();
        chk("data", out_data, e.d);
        chk("ch", out_ch, e.ch);
        chk("last", out_last, e.last);
        held = 0;
      end else begin
        held = 1;
        hd = out_data;
        hc = out_ch;
        hl = out_last;
      end
      tick();
      cyc++;
    end
    capture_valid = 0;
    out_ready = 0;
    chk("timeout", q.size(), 0);
    if (mode == 0) chk("drain_cycles", cyc, N);
    chk("idle_ready", capture_ready, 1);
    chk("idle_valid", out_valid, 0);
  endtask
  initial begin
    logic [N*DW-1:0] v;
    #2;
    chk("reset_ready", capture_ready, 1);
    chk("reset_valid", out_valid, 0);
    chk("reset_last", out_last, 0);
    chk("reset_data", out_data, 0);
    chk("reset_ch", out_ch, 0);
    chk("reset_fc", frame_count, 0);
    tick();
    arst_in = 0;
    tick();
    capture(ramp(), 0);
    drain(0, -1, -1);
    chk("fc_basic", frame_count, 1);
    v = ramp();
    v[0 +: DW] = 16'h8000;
    capture(v, 1);
    drain(0, -1, -1);
    chk("fc_relu", frame_count, 2);
    capture(ramp(), 0);
    drain(1, -1, -1);
    chk("fc_bp", frame_count, 3);
    v = ramp();
    v[3*DW +: DW] = 16'h1234;
    capture(v, 0);
    drain(0, 5, -1);
    chk("fc_blk", frame_count, 4);
    capture(~ramp(), 1);
    drain(0, -1, -1);
    chk("fc_after_blk", frame_count, 5);
    capture(ramp(), 0);
    drain(0, -1, 9);
    chk("fc_after_rst", frame_count, 0);
    capture(ramp(), 0);
    drain(0, -1, -1);
    chk("fc_post_rst", frame_count, 1);
    force dut.frame_count = 16'hFFFF;
    tick();
    release dut.frame_count;
    tick();
    chk("fc_preload", frame_count, 16'hFFFF);
    capture(ramp(), 1);
    drain(0, -1, -1);
    chk("fc_wrap", frame_count, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
